// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        DRAIN = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
    localparam logic [4:0]  EXC_NONE  = 5'd0;
    localparam logic [4:0]  EXC_ADEL  = 5'd4;

endpackage
`default_nettype wire

// File: rtl/f_d_reg.sv
`default_nettype none
// ============================================================================
// Module      : f_d_reg
// Description : F/D pipeline register (PC, instruction, optional exception
//               code when FETCH_EXC_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module f_d_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
`ifdef FETCH_EXC_EN
    input  logic [4:0]  i_exc,
    output logic [4:0]  o_exc,
`endif
    output logic [31:0] o_pc,
    output logic [31:0] o_instr
);

    logic [31:0] r_pc;
    logic [31:0] r_instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= 32'h0;
            r_instr <= INSTR_NOP;
        end else if (i_en) begin
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end
    end

    assign o_pc    = r_pc;
    assign o_instr = r_instr;

`ifdef FETCH_EXC_EN
    logic [4:0] r_exc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exc <= EXC_NONE;
        end else if (i_en) begin
            r_exc <= i_exc;
        end
    end

    assign o_exc = r_exc;
`endif

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : MIPS instruction-fetch stage with single-outstanding memory
//               handshake. FETCH_EXC_EN adds the AdEL address check.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_SIZE  = 32'h0000_4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] NPC,
    input  logic        stall,
    output logic [31:0] F_PC,
    output logic        F_wait,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic [31:0] D_PC,
`ifdef FETCH_EXC_EN
    output logic [4:0]  D_ExcCode,
`endif
    output logic [31:0] D_Instr
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  r_hold_word;
    logic [31:0]  w_word;
    logic         w_req;
    logic         w_capture;
    logic         w_avail;
    logic         w_advance;

`ifdef FETCH_EXC_EN
    logic         r_hold_exc;
    logic         w_pc_bad;
    logic         w_bad_take;
    logic [4:0]   w_exc;

    // 33-bit compare so IM_BASE + IM_SIZE cannot wrap.
    assign w_pc_bad = (r_pc[1:0] != 2'b00)
                    | ({1'b0, r_pc} <  {1'b0, IM_BASE})
                    | ({1'b0, r_pc} >= ({1'b0, IM_BASE} + {1'b0, IM_SIZE}));
    assign w_exc    = ((r_state == HOLD) && r_hold_exc) ? EXC_ADEL : EXC_NONE;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_capture   = 1'b0;
`ifdef FETCH_EXC_EN
        w_bad_take  = 1'b0;
`endif
        case (r_state)
            REQ: begin
`ifdef FETCH_EXC_EN
                if (w_pc_bad) begin
                    w_bad_take  = 1'b1;
                    w_state_nxt = HOLD;
                end else
`endif
                begin
                    w_req = 1'b1;
                    if (im_ready) begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (im_rvalid) begin
                    if (stall) begin
                        w_capture   = 1'b1;
                        w_state_nxt = HOLD;
                    end else begin
                        w_state_nxt = REQ;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    w_state_nxt = REQ;
                end
            end
            DRAIN: begin
                if (im_rvalid) begin
                    w_state_nxt = REQ;
                end
            end
            default: w_state_nxt = REQ;
        endcase
    end

    // F_wait depends only on state and im_rvalid, never on stall.
    assign w_avail   = (r_state == HOLD) | ((r_state == WAIT) & im_rvalid);
    assign w_advance = w_avail & ~stall;
    assign w_word    = (r_state == HOLD) ? r_hold_word : im_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            // A request left in flight must have its response drained.
            if (r_state == WAIT) begin
                r_state <= DRAIN;
            end else begin
                r_state <= REQ;
            end
            r_pc        <= PC_RESET;
            r_hold_word <= INSTR_NOP;
`ifdef FETCH_EXC_EN
            r_hold_exc  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_advance) begin
                r_pc <= NPC;
            end
            if (w_capture) begin
                r_hold_word <= im_rdata;
`ifdef FETCH_EXC_EN
                r_hold_exc  <= 1'b0;
`endif
            end
`ifdef FETCH_EXC_EN
            if (w_bad_take) begin
                r_hold_word <= INSTR_NOP;
                r_hold_exc  <= 1'b1;
            end
`endif
        end
    end

    assign F_PC    = r_pc;
    assign F_wait  = ~w_avail;
    assign im_req  = w_req & ~reset;
    assign im_addr = r_pc;

    f_d_reg u_f_d_reg (
        .clk     (clk),
        .rst     (reset),
        .i_en    (w_advance),
        .i_pc    (r_pc),
        .i_instr (w_word),
`ifdef FETCH_EXC_EN
        .i_exc   (w_exc),
        .o_exc   (D_ExcCode),
`endif
        .o_pc    (D_PC),
        .o_instr (D_Instr)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage: directed vectors,
//               reset-drain sequence and a randomized memory/stall model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] NPC;
    logic        stall;
    logic [31:0] F_PC;
    logic        F_wait;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ready;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic [31:0] D_PC;
    logic [31:0] D_Instr;
`ifdef FETCH_EXC_EN
    logic [4:0]  D_ExcCode;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk       (clk),
        .reset     (reset),
        .NPC       (NPC),
        .stall     (stall),
        .F_PC      (F_PC),
        .F_wait    (F_wait),
        .im_req    (im_req),
        .im_addr   (im_addr),
        .im_ready  (im_ready),
        .im_rvalid (im_rvalid),
        .im_rdata  (im_rdata),
        .D_PC      (D_PC),
`ifdef FETCH_EXC_EN
        .D_ExcCode (D_ExcCode),
`endif
        .D_Instr   (D_Instr)
    );

    typedef struct {
        logic        rst, stl, rdy, rv;
        logic [31:0] rdata, npc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_wait;
        logic [31:0] e_fpc, e_dpc, e_dinstr;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic rdy, input logic rv,
                         input logic [31:0] rd, input logic [31:0] np);
        reset     = r;
        stall     = s;
        im_ready  = rdy;
        im_rvalid = rv;
        im_rdata  = rd;
        NPC       = np;
    endtask

    task automatic step_chk(input string nm, input vec_t v);
        @(negedge clk);
        drive(v.rst, v.stl, v.rdy, v.rv, v.rdata, v.npc);
        #1;
        chk({nm, ".im_req"},  {31'b0, im_req}, {31'b0, v.e_req});
        chk({nm, ".im_addr"}, im_addr, v.e_addr);
        chk({nm, ".F_wait"},  {31'b0, F_wait}, {31'b0, v.e_wait});
        @(posedge clk);
        #1;
        chk({nm, ".F_PC"},    F_PC,    v.e_fpc);
        chk({nm, ".D_PC"},    D_PC,    v.e_dpc);
        chk({nm, ".D_Instr"}, D_Instr, v.e_dinstr);
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic rdy, input logic rv,
                                input logic [31:0] rd, input logic [31:0] np,
                                input logic er, input logic [31:0] ea, input logic ew,
                                input logic [31:0] ef, input logic [31:0] ed,
                                input logic [31:0] ei);
        vec_t v;
        v.rst = r; v.stl = s; v.rdy = rdy; v.rv = rv; v.rdata = rd; v.npc = np;
        v.e_req = er; v.e_addr = ea; v.e_wait = ew;
        v.e_fpc = ef; v.e_dpc = ed; v.e_dinstr = ei;
        return v;
    endfunction

    // Random-phase reference state
    logic [31:0] m_pc, m_dpc, m_dinstr, r_npc, r_rdata;
    logic        m_out, m_have, m_need, m_avail, r_rdy, r_rv, r_stl;
    int          m_delay;

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h3004);
        repeat (2) @(posedge clk);

        // Fetch, ready-low hold, stall/HOLD, branch, spurious rvalid.
        vecs[0]  = mk(1,0,0,0,32'h0,        32'h3004, 0,32'h3000,1, 32'h3000,32'h0,   32'h0);
        vecs[1]  = mk(0,0,1,0,32'h0,        32'h3004, 1,32'h3000,1, 32'h3000,32'h0,   32'h0);
        vecs[2]  = mk(0,0,0,1,32'h3402_0005,32'h3004, 0,32'h3000,0, 32'h3004,32'h3000,32'h3402_0005);
        vecs[3]  = mk(0,0,0,0,32'h0,        32'h3008, 1,32'h3004,1, 32'h3004,32'h3000,32'h3402_0005);
        vecs[4]  = vecs[3];
        vecs[5]  = vecs[3];
        vecs[6]  = mk(0,0,1,0,32'h0,        32'h3008, 1,32'h3004,1, 32'h3004,32'h3000,32'h3402_0005);
        vecs[7]  = mk(0,0,0,0,32'h0,        32'h3008, 0,32'h3004,1, 32'h3004,32'h3000,32'h3402_0005);
        vecs[8]  = mk(0,1,0,1,32'hAAAA_0001,32'h3008, 0,32'h3004,0, 32'h3004,32'h3000,32'h3402_0005);
        vecs[9]  = mk(0,1,0,1,32'hEEEE_0009,32'h3008, 0,32'h3004,0, 32'h3004,32'h3000,32'h3402_0005);
        vecs[10] = mk(0,0,0,0,32'h0,        32'h3100, 0,32'h3004,0, 32'h3100,32'h3004,32'hAAAA_0001);
        vecs[11] = mk(0,0,1,0,32'h0,        32'h3104, 1,32'h3100,1, 32'h3100,32'h3004,32'hAAAA_0001);
        vecs[12] = mk(0,0,0,1,32'hBBBB_0002,32'h3104, 0,32'h3100,0, 32'h3104,32'h3100,32'hBBBB_0002);
        vecs[13] = mk(0,0,0,1,32'hCCCC_0003,32'h3108, 1,32'h3104,1, 32'h3104,32'h3100,32'hBBBB_0002);
        for (int i = 0; i < 14; i++) begin
            step_chk($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset while a request is in flight: stale response must be dropped.
        step_chk("drain_a", mk(0,0,1,0,32'h0,32'h3108, 1,32'h3104,1, 32'h3104,32'h3100,32'hBBBB_0002));
        step_chk("drain_b", mk(1,0,0,0,32'h0,32'h3108, 0,32'h3104,1, 32'h3000,32'h0,32'h0));
        step_chk("drain_c", mk(0,0,1,0,32'h0,32'h3004, 0,32'h3000,1, 32'h3000,32'h0,32'h0));
        step_chk("drain_d", mk(0,0,1,1,32'hDEAD_BEEF,32'h3004, 0,32'h3000,1, 32'h3000,32'h0,32'h0));
        step_chk("drain_e", mk(0,0,1,0,32'h0,32'h3004, 1,32'h3000,1, 32'h3000,32'h0,32'h0));
        step_chk("drain_f", mk(0,0,0,1,32'h1111_2222,32'h3004, 0,32'h3000,0, 32'h3004,32'h3000,32'h1111_2222));

        // Randomized run against a transaction-level model of the stage.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h3004);
        @(posedge clk);
        m_pc = 32'h3000; m_dpc = 32'h0; m_dinstr = 32'h0;
        m_out = 1'b0; m_have = 1'b0; m_delay = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            m_need  = !m_out && !m_have;
            r_rdy   = ($urandom_range(0, 2) != 0);
            r_rv    = m_out && (m_delay == 0);
            if (!m_out && $urandom_range(0, 7) == 0) r_rv = 1'b1;
            r_rdata = m_out ? mem_word(m_pc) : $urandom;
            r_stl   = ($urandom_range(0, 3) == 0);
            r_npc   = ($urandom_range(0, 3) == 0) ? 32'h3000 + ($urandom_range(0, 32'hFF0) << 2)
                                                  : m_pc + 32'd4;
            drive(1'b0, r_stl, r_rdy, r_rv, r_rdata, r_npc);
            m_avail = m_have || (m_out && r_rv);
            #1;
            chk("rnd.im_req", {31'b0, im_req}, {31'b0, m_need});
            if (m_need) chk("rnd.im_addr", im_addr, m_pc);
            chk("rnd.F_wait", {31'b0, F_wait}, {31'b0, !m_avail});
            @(posedge clk);
            if (m_avail && !r_stl) begin
                m_dpc    = m_pc;
                m_dinstr = mem_word(m_pc);
                m_pc     = r_npc;
                m_have   = 1'b0;
                m_out    = 1'b0;
            end else if (m_avail) begin
                m_have = 1'b1;
                m_out  = 1'b0;
            end else if (m_out) begin
                m_delay--;
            end
            if (m_need && r_rdy) begin
                m_out   = 1'b1;
                m_delay = $urandom_range(0, 3);
            end
            #1;
            chk("rnd.F_PC",    F_PC,    m_pc);
            chk("rnd.D_PC",    D_PC,    m_dpc);
            chk("rnd.D_Instr", D_Instr, m_dinstr);
        end

`ifdef FETCH_EXC_EN
        // Misaligned and out-of-range PCs fetch nothing and raise AdEL.
        step_chk("exc_rst", mk(1,0,0,0,32'h0,32'h3004, 0,32'h3000,1, 32'h3000,32'h0,32'h0));
        chk("exc_rst.code", {27'b0, D_ExcCode}, 32'd0);
        step_chk("exc_a", mk(0,0,1,0,32'h0,32'h3002, 1,32'h3000,1, 32'h3000,32'h0,32'h0));
        step_chk("exc_b", mk(0,0,0,1,32'h1234_0001,32'h3002, 0,32'h3000,0, 32'h3002,32'h3000,32'h1234_0001));
        chk("exc_b.code", {27'b0, D_ExcCode}, 32'd0);
        step_chk("exc_c", mk(0,0,1,0,32'h0,32'h3000, 0,32'h3002,1, 32'h3002,32'h3000,32'h1234_0001));
        step_chk("exc_d", mk(0,0,0,0,32'h0,32'h3000, 0,32'h3002,0, 32'h3000,32'h3002,32'h0));
        chk("exc_d.code", {27'b0, D_ExcCode}, 32'd4);
        step_chk("exc_e", mk(0,0,1,0,32'h0,32'h7000, 1,32'h3000,1, 32'h3000,32'h3002,32'h0));
        step_chk("exc_f", mk(0,0,0,1,32'h5678_0002,32'h7000, 0,32'h3000,0, 32'h7000,32'h3000,32'h5678_0002));
        chk("exc_f.code", {27'b0, D_ExcCode}, 32'd0);
        step_chk("exc_g", mk(0,0,1,0,32'h0,32'h3000, 0,32'h7000,1, 32'h7000,32'h3000,32'h5678_0002));
        step_chk("exc_h", mk(0,0,0,0,32'h0,32'h3000, 0,32'h7000,0, 32'h3000,32'h7000,32'h0));
        chk("exc_h.code", {27'b0, D_ExcCode}, 32'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
